// File: rtl/put_arbiter_pkg.sv
// Shared types and helpers for the round-robin FIFO put arbiter.
package put_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_e;

  // Burst counter must hold 0..MAX_BURST-1; one extra code keeps MAX_BURST=1 at width 1.
  function automatic int burst_cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

  // Round-robin mask bit: positions strictly above the last owner get first pick.
  function automatic logic rr_above_last(input int unsigned idx, input int unsigned last);
    return idx > last;
  endfunction

endpackage

// File: rtl/put_arbiter_if.sv
// Producer/FIFO-side bundle of the put arbiter; master is the arbiter, slave the environment.
interface put_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_put;
  logic [NUM_REQ*DATA_WIDTH-1:0] data_in;
  logic                          full;
  logic                          en_put;
  logic [DATA_WIDTH-1:0]         data_out;
  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0]            ack;

  modport master (
    input  req_put, data_in, full,
    output en_put, data_out, grant, ack
  );

  modport slave (
    output req_put, data_in, full,
    input  en_put, data_out, grant, ack
  );
endinterface

// File: rtl/put_arbiter_rr_select.sv
// Combinational round-robin picker: first set request strictly after i_last, wrapping.
module rr_select
  import put_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDXW-1:0]    i_last,
  output logic [NUM_REQ-1:0] o_win
);

  logic [NUM_REQ-1:0] w_mask;
  logic [NUM_REQ-1:0] w_hi;
  logic [NUM_REQ-1:0] w_pool;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign w_mask[gi] = rr_above_last(gi, 32'(i_last));
    end
  endgenerate

  // Prefer requests above the last owner; otherwise wrap to the lowest index.
  assign w_hi   = i_req & w_mask;
  assign w_pool = (|w_hi) ? w_hi : i_req;
  assign o_win  = w_pool & (~w_pool + 1'b1);

endmodule

// File: rtl/put_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers with a burst cap.
module put_arbiter
  import put_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic          clk,
  input  logic          rst,
  put_arbiter_if.master bus
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int CNTW = burst_cnt_width(MAX_BURST);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MAX_BURST - 1);
  localparam logic [IDXW-1:0] LAST_RST = IDXW'(NUM_REQ - 1);

  state_e               r_state;
  logic [NUM_REQ-1:0]   r_grant;
  logic [CNTW-1:0]      r_burst_cnt;
  logic [IDXW-1:0]      r_last;

  logic                  w_owner_req;
  logic                  w_en_put;
  logic                  w_cap;
  logic                  w_release;
  logic [IDXW-1:0]       w_owner_idx;
  logic [IDXW-1:0]       w_arb_last;
  logic [NUM_REQ-1:0]    w_win;
  logic [DATA_WIDTH-1:0] w_data;

  assign w_owner_req = |(r_grant & bus.req_put);
  assign w_en_put    = w_owner_req & ~bus.full;
  assign w_cap       = w_en_put && (r_burst_cnt == CNT_LAST);
  assign w_release   = (r_state == OWNED) && (!w_owner_req || w_cap);

  // Searching from the owner's own index makes the owner the last candidate,
  // so a capped owner is re-granted only when nobody else is waiting.
  assign w_arb_last  = (r_state == OWNED) ? w_owner_idx : r_last;

  always_comb begin
    w_owner_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_owner_idx = IDXW'(i);
      end
    end
  end

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_data = w_data | (bus.data_in[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{r_grant[i]}});
    end
  end

  rr_select #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_select (
    .i_req  (bus.req_put),
    .i_last (w_arb_last),
    .o_win  (w_win)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_burst_cnt <= '0;
      r_last      <= LAST_RST;
    end else begin
      case (r_state)
        IDLE: begin
          if (|bus.req_put) begin
            r_grant     <= w_win;
            r_burst_cnt <= '0;
            r_state     <= OWNED;
          end
        end
        OWNED: begin
          if (w_release) begin
            r_last      <= w_owner_idx;
            r_burst_cnt <= '0;
            r_grant     <= w_win;
            r_state     <= (|w_win) ? OWNED : IDLE;
          end else if (w_en_put) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign bus.en_put   = w_en_put;
  assign bus.ack      = r_grant & {NUM_REQ{w_en_put}};
  assign bus.grant    = r_grant;
  assign bus.data_out = w_data;

endmodule

// File: tb/tb_put_arbiter.sv
// Directed bench: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_put_arbiter;

  logic clk;
  logic rst;

  put_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

  put_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .MAX_BURST  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       full;
    logic [3:0] grant;
    logic       en;
    logic [3:0] ack;
    logic [7:0] dout;
  } vec_t;

  vec_t       vecs[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] bytes[4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
  int         ack1_cnt;

  function automatic void add(input logic r, input logic [3:0] q, input logic f,
                              input logic [3:0] g, input logic e, input logic [3:0] a,
                              input logic [7:0] d);
    vec_t v;
    v.rst = r; v.req = q; v.full = f; v.grant = g; v.en = e; v.ack = a; v.dout = d;
    vecs.push_back(v);
  endfunction

  function automatic void add_burst(input logic [3:0] q, input int owner);
    logic [3:0] oh;
    oh = 4'(1 << owner);
    for (int k = 0; k < 4; k++) add(1'b0, q, 1'b0, oh, 1'b1, oh, bytes[owner]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] q, input logic f);
    @(negedge clk);
    rst         = r;
    bus.req_put = q;
    bus.full    = f;
    #1;
    if (bus.ack[1]) ack1_cnt++;
    $display("step rst=%b req=%b full=%b grant=%b en=%b ack=%b dout=%h",
             r, q, f, bus.grant, bus.en_put, bus.ack, bus.data_out);
  endtask

  task automatic chk_out(input string name, input logic [3:0] g, input logic e,
                         input logic [3:0] a);
    chk({name, ".grant"}, 32'(bus.grant), 32'(g));
    chk({name, ".en"}, 32'(bus.en_put), 32'(e));
    chk({name, ".ack"}, 32'(bus.ack), 32'(a));
  endtask

  initial begin
    int own_seq[5] = '{0, 1, 2, 3, 0};

    rst         = 1'b1;
    bus.req_put = 4'b0000;
    bus.full    = 1'b0;
    bus.data_in = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    repeat (2) @(negedge clk);

    // reset state
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00);
    // single requester: re-grant on cap with no gap
    add(1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00);
    for (int k = 0; k < 10; k++) add(1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0001, 8'hA0);
    add(1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0000, 8'hA0);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00);
    // all requesting: rotation 0,1,2,3,0 with 4 writes each
    add(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00);
    add(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00);
    for (int k = 0; k < 5; k++) add_burst(4'b1111, own_seq[k]);
    add(1'b0, 4'b0000, 1'b0, 4'b0010, 1'b0, 4'b0000, 8'hB1);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00);
    // data routing with req=1010
    add(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00);
    add(1'b0, 4'b1010, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00);
    add_burst(4'b1010, 1);
    add_burst(4'b1010, 3);
    add_burst(4'b1010, 1);
    add(1'b0, 4'b0000, 1'b0, 4'b1000, 1'b0, 4'b0000, 8'hD3);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst         = vecs[i].rst;
      bus.req_put = vecs[i].req;
      bus.full    = vecs[i].full;
      #1;
      $display("vec %0d rst=%b req=%b full=%b grant=%b en=%b ack=%b dout=%h",
               i, vecs[i].rst, vecs[i].req, vecs[i].full,
               bus.grant, bus.en_put, bus.ack, bus.data_out);
      chk($sformatf("vec%0d.grant", i), 32'(bus.grant), 32'(vecs[i].grant));
      chk($sformatf("vec%0d.en", i), 32'(bus.en_put), 32'(vecs[i].en));
      chk($sformatf("vec%0d.ack", i), 32'(bus.ack), 32'(vecs[i].ack));
      chk($sformatf("vec%0d.dout", i), 32'(bus.data_out), 32'(vecs[i].dout));
    end

    // full stall mid-burst: count frozen, then 3 more writes and rotate
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b1100, 1'b0);
    chk_out("full.idle", 4'b0000, 1'b0, 4'b0000);
    step(1'b0, 4'b1100, 1'b0);
    chk_out("full.w1", 4'b0100, 1'b1, 4'b0100);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'b1100, 1'b1);
      chk_out($sformatf("full.stall%0d", k), 4'b0100, 1'b0, 4'b0000);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'b1100, 1'b0);
      chk_out($sformatf("full.resume%0d", k), 4'b0100, 1'b1, 4'b0100);
    end
    step(1'b0, 4'b1100, 1'b0);
    chk_out("full.rotate", 4'b1000, 1'b1, 4'b1000);

    // owner drops request early: grant moves straight to the pending requester
    step(1'b1, 4'b0000, 1'b0);
    ack1_cnt = 0;
    step(1'b0, 4'b1010, 1'b0);
    chk_out("drop.idle", 4'b0000, 1'b0, 4'b0000);
    step(1'b0, 4'b1010, 1'b0);
    step(1'b0, 4'b1010, 1'b0);
    chk_out("drop.w2", 4'b0010, 1'b1, 4'b0010);
    step(1'b0, 4'b1000, 1'b0);
    chk_out("drop.release", 4'b0010, 1'b0, 4'b0000);
    step(1'b0, 4'b1000, 1'b0);
    chk_out("drop.move", 4'b1000, 1'b1, 4'b1000);
    chk("drop.ack1_cnt", 32'(ack1_cnt), 32'd2);

    // reset mid-burst: pointer returns to 3 so requester 0 wins next
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b1000, 1'b0);
    step(1'b0, 4'b1000, 1'b0);
    step(1'b0, 4'b1000, 1'b0);
    chk_out("rst.w2", 4'b1000, 1'b1, 4'b1000);
    step(1'b1, 4'b1111, 1'b0);
    step(1'b0, 4'b1111, 1'b0);
    chk_out("rst.cleared", 4'b0000, 1'b0, 4'b0000);
    step(1'b0, 4'b1111, 1'b0);
    chk_out("rst.first", 4'b0001, 1'b1, 4'b0001);
    chk("rst.dout", 32'(bus.data_out), 32'h0000_00A0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
